// File: rtl/page_dispatcher_pkg.sv
// Shared types and constants for the page dispatcher: core/beat/size widths, FSM states
// and the tkeep byte counter.
package page_dispatcher_pkg;

    localparam int COMP_CORES    = 6;
    localparam int AXI_DATA_BITS = 512;
    localparam int KEEP_BITS     = AXI_DATA_BITS / 8;
    localparam int PAGE_SIZE     = 8192;
    localparam int PAGE_BEATS    = PAGE_SIZE / KEEP_BITS;
    localparam int VADDR_BITS    = 48;

    typedef logic [$clog2(COMP_CORES)-1:0]  core_idx_t;
    typedef logic [$clog2(PAGE_BEATS)-1:0]  page_beat_t;
    // One extra bit so a full page (exactly PAGE_SIZE bytes) is representable.
    typedef logic [$clog2(PAGE_SIZE+1)-1:0] page_size_t;
    typedef logic [$clog2(KEEP_BITS+1)-1:0] keep_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        STREAM,
        DESC
    } dispatch_state_t;

    function automatic keep_cnt_t popcount_keep(input logic [KEEP_BITS-1:0] keep);
        keep_cnt_t n;
        n = '0;
        for (int i = 0; i < KEEP_BITS; i++) begin
            n = n + keep_cnt_t'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/page_dispatcher_rr_core_select.sv
// Combinational round-robin picker: first requesting core at or after ptr, wrapping.
module rr_core_select
    import page_dispatcher_pkg::*;
(
    input  logic [COMP_CORES-1:0] req,
    input  core_idx_t             ptr,
    output core_idx_t             grant_idx,
    output logic                  grant_valid
);

    // Walk from the farthest offset down so the nearest idle core wins last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = COMP_CORES - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % COMP_CORES]) begin
                grant_idx   = core_idx_t'((int'(ptr) + k) % COMP_CORES);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/page_dispatcher.sv
// Splits one AXI4-Stream job into fixed-size pages, steers each page to an idle core and
// emits a descriptor per page. Per-core page counters exist only with PAGE_DISPATCH_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for cfg_start; input stream stalled
// SELECT | choosing the next idle core round-robin
// STREAM | zero-latency pass-through of one page to the selected core
// DESC   | presenting the page descriptor until desc_ready
module page_dispatcher
    import page_dispatcher_pkg::*;
(
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_start,
    input  logic [VADDR_BITS-1:0]       cfg_vaddr,
    output logic                        cfg_busy,
    input  logic [AXI_DATA_BITS-1:0]    s_axis_tdata,
    input  logic [KEEP_BITS-1:0]        s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [COMP_CORES-1:0]       core_idle,
    output logic [AXI_DATA_BITS-1:0]    m_axis_tdata,
    output logic [KEEP_BITS-1:0]        m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [COMP_CORES-1:0]       m_axis_tvalid,
    input  logic [COMP_CORES-1:0]       m_axis_tready,
    output logic [VADDR_BITS-1:0]       desc_vaddr,
    output core_idx_t                   desc_core,
    output page_size_t                  desc_size,
    output logic                        desc_last,
    output logic                        desc_valid,
    input  logic                        desc_ready,
    output logic [COMP_CORES*32-1:0]    stat_pages
);

    localparam int N_CORES = COMP_CORES;
    localparam int BEATS   = PAGE_BEATS;

    dispatch_state_t        state, state_nxt;
    core_idx_t              rr_ptr, sel_q;
    page_beat_t             beat_cnt;
    page_size_t             byte_cnt;
    logic [VADDR_BITS-1:0]  vaddr_q;
    logic                   last_q;
    core_idx_t              grant_idx;
    logic                   grant_valid;
    logic                   beat_hs;
    logic                   desc_hs;

    rr_core_select u_rr_core_select (
        .req         (core_idle),
        .ptr         (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        desc_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nxt = SELECT;
            end
            SELECT: begin
                if (grant_valid) state_nxt = STREAM;
            end
            STREAM: begin
                s_axis_tready = m_axis_tready[sel_q];
                m_axis_tvalid = N_CORES'(s_axis_tvalid) << sel_q;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast | (beat_cnt == page_beat_t'(BEATS - 1));
                if (s_axis_tvalid && s_axis_tready && m_axis_tlast) state_nxt = DESC;
            end
            DESC: begin
                desc_valid = 1'b1;
                if (desc_ready) state_nxt = last_q ? IDLE : SELECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign beat_hs = (state == STREAM) && s_axis_tvalid && s_axis_tready;
    assign desc_hs = (state == DESC) && desc_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sel_q    <= '0;
            beat_cnt <= '0;
            byte_cnt <= '0;
            vaddr_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cfg_start) vaddr_q <= cfg_vaddr;
                end
                SELECT: begin
                    if (grant_valid) begin
                        sel_q  <= grant_idx;
                        rr_ptr <= (grant_idx == core_idx_t'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                STREAM: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        byte_cnt <= byte_cnt + page_size_t'(popcount_keep(s_axis_tkeep));
                        if (m_axis_tlast) last_q <= s_axis_tlast;
                    end
                end
                DESC: begin
                    if (desc_ready) begin
                        vaddr_q  <= vaddr_q + VADDR_BITS'(PAGE_SIZE);
                        beat_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_busy   = (state != IDLE);
    assign desc_vaddr = vaddr_q;
    assign desc_core  = sel_q;
    assign desc_size  = byte_cnt;
    assign desc_last  = last_q;

`ifdef PAGE_DISPATCH_STATS_EN
    logic [31:0] stat_cnt [N_CORES];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CORES; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (desc_hs && (sel_q == core_idx_t'(i))) stat_cnt[i] <= stat_cnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_pages = '0;
        for (int i = 0; i < N_CORES; i++) stat_pages[i*32 +: 32] = stat_cnt[i];
    end
`else
    assign stat_pages = '0;
`endif

endmodule

// File: tb/tb_page_dispatcher.sv
// Directed bench for page_dispatcher: paging, round-robin core choice, backpressure and reset.
`timescale 1ns/1ps
module tb_page_dispatcher;
    import page_dispatcher_pkg::*;

    localparam int NC = COMP_CORES;
    localparam int KB = KEEP_BITS;

    logic                     aclk = 1'b0;
    logic                     aresetn;
    logic                     cfg_start;
    logic [VADDR_BITS-1:0]    cfg_vaddr;
    logic                     cfg_busy;
    logic [AXI_DATA_BITS-1:0] s_axis_tdata;
    logic [KB-1:0]            s_axis_tkeep;
    logic                     s_axis_tlast;
    logic                     s_axis_tvalid;
    logic                     s_axis_tready;
    logic [NC-1:0]            core_idle;
    logic [AXI_DATA_BITS-1:0] m_axis_tdata;
    logic [KB-1:0]            m_axis_tkeep;
    logic                     m_axis_tlast;
    logic [NC-1:0]            m_axis_tvalid;
    logic [NC-1:0]            m_axis_tready;
    logic [VADDR_BITS-1:0]    desc_vaddr;
    core_idx_t                desc_core;
    page_size_t               desc_size;
    logic                     desc_last;
    logic                     desc_valid;
    logic                     desc_ready;
    logic [NC*32-1:0]         stat_pages;

    always #5 aclk = ~aclk;

    page_dispatcher dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_start     (cfg_start),
        .cfg_vaddr     (cfg_vaddr),
        .cfg_busy      (cfg_busy),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .core_idle     (core_idle),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .desc_vaddr    (desc_vaddr),
        .desc_core     (desc_core),
        .desc_size     (desc_size),
        .desc_last     (desc_last),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .stat_pages    (stat_pages)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records pages seen on the core side and descriptor handshakes.
    int                    seq_rx = 0;
    int                    seq_err = 0, onehot_err = 0, stab_err = 0, rdy_err = 0;
    int                    pbeat = 0;
    int                    pg_n = 0;
    int                    pg_beats [64];
    int                    pg_core  [64];
    int                    d_n = 0;
    logic [63:0]           d_vaddr [64];
    int                    d_core  [64];
    int                    d_size  [64];
    int                    d_last  [64];
    int                    mon_core;
    logic                  hold_v = 1'b0;
    logic [VADDR_BITS-1:0] h_vaddr;
    core_idx_t             h_core;
    page_size_t            h_size;
    logic                  h_last;

    always @(negedge aclk) begin
        #2;
        if (!aresetn) begin
            pbeat  = 0;
            hold_v = 1'b0;
        end else begin
            if ($countones(m_axis_tvalid) > 1) onehot_err++;
            if (desc_valid && s_axis_tready) rdy_err++;
            if (hold_v && !(desc_valid && desc_vaddr == h_vaddr && desc_core == h_core &&
                            desc_size == h_size && desc_last == h_last)) stab_err++;
            if ((m_axis_tvalid & m_axis_tready) != '0) begin
                if (m_axis_tdata[31:0] !== seq_rx[31:0]) seq_err++;
                seq_rx++;
                pbeat++;
                mon_core = -1;
                for (int i = 0; i < NC; i++) if (m_axis_tvalid[i]) mon_core = i;
                if (m_axis_tlast && pg_n < 64) begin
                    pg_beats[pg_n] = pbeat;
                    pg_core[pg_n]  = mon_core;
                    pg_n++;
                    pbeat = 0;
                end
            end
            hold_v = desc_valid && !desc_ready;
            h_vaddr = desc_vaddr;
            h_core  = desc_core;
            h_size  = desc_size;
            h_last  = desc_last;
            if (desc_valid && desc_ready && d_n < 64) begin
                d_vaddr[d_n] = 64'(desc_vaddr);
                d_core[d_n]  = int'(desc_core);
                d_size[d_n]  = int'(desc_size);
                d_last[d_n]  = int'(desc_last);
                d_n++;
            end
        end
    end

    // Environment / driver
    logic slow_desc = 1'b0;
    logic rnd_ready = 1'b0;
    int   dcnt = 0;
    int   tx_seq = 0;
    int   to_err = 0;

    task automatic env(output logic hs);
        if (rnd_ready) m_axis_tready = NC'($urandom);
        #1;
        if (slow_desc) begin
            desc_ready = desc_valid && (dcnt >= 5);
            dcnt = (desc_valid && !desc_ready) ? dcnt + 1 : 0;
        end
        hs = s_axis_tvalid && s_axis_tready;
    endtask

    task automatic send(input int n, input logic last_job, input logic [KB-1:0] last_keep);
        int   b = 0;
        int   budget = 0;
        logic hs;
        while (b < n) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {16{tx_seq[31:0]}};
            s_axis_tlast  = last_job && (b == n - 1);
            s_axis_tkeep  = s_axis_tlast ? last_keep : '1;
            env(hs);
            if (hs) begin
                b++;
                tx_seq++;
                budget = 0;
            end else if (++budget > 2000) begin
                to_err++;
                $display("FAIL send_timeout: beat %0d of %0d not accepted", b, n);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        logic hs;
        for (int c = 0; c < 2000; c++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            env(hs);
            if (!cfg_busy) return;
        end
        to_err++;
        $display("FAIL idle_timeout: cfg_busy still high");
    endtask

    task automatic start_job(input logic [VADDR_BITS-1:0] va);
        @(negedge aclk);
        cfg_vaddr = va;
        cfg_start = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_start     = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic chk_page(input string tag, input int idx, input int core, input int beats);
        chk({tag, "_pg_core"}, 64'(pg_core[idx]), 64'(core));
        chk({tag, "_pg_beats"}, 64'(pg_beats[idx]), 64'(beats));
    endtask

    task automatic chk_desc(input string tag, input int idx, input logic [63:0] va,
                            input int core, input int size, input int last);
        chk({tag, "_d_vaddr"}, d_vaddr[idx], va);
        chk({tag, "_d_core"}, 64'(d_core[idx]), 64'(core));
        chk({tag, "_d_size"}, 64'(d_size[idx]), 64'(size));
        chk({tag, "_d_last"}, 64'(d_last[idx]), 64'(last));
    endtask

`ifdef PAGE_DISPATCH_STATS_EN
    localparam logic [63:0] STAT_LO_END = 64'd1;
`else
    localparam logic [63:0] STAT_LO_END = 64'd0;
`endif

    initial begin
        logic hs;
        aresetn       = 1'b0;
        cfg_start     = 1'b0;
        cfg_vaddr     = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        core_idle     = '1;
        m_axis_tready = '1;
        desc_ready    = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_desc_valid", 64'(desc_valid), 64'd0);
        chk("rst_desc_vaddr", 64'(desc_vaddr), 64'd0);
        chk("rst_desc_size", 64'(desc_size), 64'd0);
        chk("rst_stat_lo", stat_pages[63:0], 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // 1: one full page, tlast on beat 127
        start_job(48'h1000);
        send(128, 1'b1, '1);
        wait_idle();
        chk("t1_pages", 64'(pg_n), 64'd1);
        chk_page("t1", 0, 0, 128);
        chk("t1_descs", 64'(d_n), 64'd1);
        chk_desc("t1", 0, 64'h1000, 0, 8192, 1);
        chk("t1_busy", 64'(cfg_busy), 64'd0);

        // 2: three full pages after reset -> cores 0,1,2
        do_reset();
        start_job(48'h10000);
        send(384, 1'b1, '1);
        wait_idle();
        chk("t2_pages", 64'(pg_n), 64'd4);
        for (int i = 0; i < 3; i++) begin
            chk_page("t2", 1 + i, i, 128);
            chk_desc("t2", 1 + i, 64'h10000 + 64'(i) * 64'h2000, i, 8192, (i == 2) ? 1 : 0);
        end

        // 3: short job, partial last beat; rr_ptr carried over -> core 3
        start_job(48'h40000);
        send(10, 1'b1, 64'hFF);
        wait_idle();
        chk_page("t3", 4, 3, 10);
        chk_desc("t3", 4, 64'h40000, 3, 584, 1);
        chk("t3_busy", 64'(cfg_busy), 64'd0);

        // 4: sparse idle mask, then no idle core at all
        do_reset();
        core_idle = 6'b111010;
        start_job(48'h20000);
        send(128, 1'b0, '1);
        send(128, 1'b0, '1);
        @(negedge aclk);
        core_idle     = '0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16{tx_seq[31:0]}};
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '1;
        env(hs);
        repeat (5) begin
            @(negedge aclk);
            env(hs);
        end
        chk("t4_hold_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t4_hold_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t4_hold_busy", 64'(cfg_busy), 64'd1);
        chk("t4_hold_pages", 64'(pg_n), 64'd7);
        core_idle = '1;
        send(128, 1'b1, '1);
        wait_idle();
        chk_page("t4a", 5, 1, 128);
        chk_page("t4b", 6, 3, 128);
        chk_page("t4c", 7, 4, 128);
        chk_desc("t4a", 5, 64'h20000, 1, 8192, 0);
        chk_desc("t4b", 6, 64'h22000, 3, 8192, 0);
        chk_desc("t4c", 7, 64'h24000, 4, 8192, 1);

        // 5: random core backpressure, descriptor held off 5 cycles
        slow_desc = 1'b1;
        rnd_ready = 1'b1;
        start_job(48'h80000);
        send(300, 1'b1, 64'h0F);
        wait_idle();
        slow_desc     = 1'b0;
        rnd_ready     = 1'b0;
        m_axis_tready = '1;
        desc_ready    = 1'b1;
        chk_page("t5a", 8, 5, 128);
        chk_page("t5b", 9, 0, 128);
        chk_page("t5c", 10, 1, 44);
        chk_desc("t5a", 8, 64'h80000, 5, 8192, 0);
        chk_desc("t5b", 9, 64'h82000, 0, 8192, 0);
        chk_desc("t5c", 10, 64'h84000, 1, 2756, 1);
        chk("t5_beats_rx", 64'(seq_rx), 64'(tx_seq));
        chk("t5_seq_err", 64'(seq_err), 64'd0);
        chk("t5_stab_err", 64'(stab_err), 64'd0);
        chk("t5_rdy_in_desc", 64'(rdy_err), 64'd0);
        chk("t5_onehot_err", 64'(onehot_err), 64'd0);

        // 6: reset in the middle of a page
        start_job(48'h0);
        send(50, 1'b0, '1);
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16{tx_seq[31:0]}};
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '1;
        @(negedge aclk);
        #1;
        chk("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_desc_valid", 64'(desc_valid), 64'd0);
        chk("t6_busy", 64'(cfg_busy), 64'd0);
        chk("t6_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t6_stat_lo", stat_pages[63:0], 64'd0);
        chk("t6_stat_mid", stat_pages[127:64], 64'd0);
        chk("t6_stat_hi", stat_pages[191:128], 64'd0);
        aresetn = 1'b1;
        chk("t6_pages_dropped", 64'(pg_n), 64'd11);
        start_job(48'h3000);
        send(1, 1'b1, '1);
        wait_idle();
        chk_page("t6", 11, 0, 1);
        chk_desc("t6", 11, 64'h3000, 0, 64, 1);
        chk("t6_stat_after", stat_pages[63:0], STAT_LO_END);
        chk("t6_descs", 64'(d_n), 64'd12);
        chk("timeouts", 64'(to_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
